fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode stage in the 16-bit pipeline. It owns the PC and issues word reads to instruction memory, which has a fixed 1-cycle read latency. Returned words are buffered in a small FIFO, and the fetch stage presents one instruction per cycle to decode on instr/instr_valid. It honours the decode stall and flushes and redirects on is_branch_taken.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, instruction buffer, decode handoff
module fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        is_branch_taken,
  input  logic [ADDR_W-1:0]           branch_target,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [INSTR_W-1:0]          imem_rdata,
  output logic [INSTR_W-1:0]          instr,
  output logic [ADDR_W-1:0]           pc_out,
  output logic                        instr_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  req_addr;

  logic [INSTR_W-1:0] buf_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]  buf_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [CNT_W:0]     credit_use;

  assign fifo_empty = (count == '0);

  // A branch kills the response landing this cycle and blocks any pop.
  assign push = inflight & ~is_branch_taken;
  assign pop  = ~is_branch_taken & ~stall & ~fifo_empty;

  // Buffered entries plus the outstanding read, less what leaves this cycle,
  // must leave room for one more word or the request would overflow the FIFO.
  assign credit_use = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};

  assign imem_req   = reset & ~is_branch_taken & (credit_use < DEPTH_C);
  assign imem_addr  = pc;
  assign fifo_count = count;

  // PC advance / redirect and tracking of the single outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      req_addr <= '0;
    end else begin
      inflight <= imem_req;
      if (is_branch_taken) begin
        pc <= branch_target;
      end else if (imem_req) begin
        pc       <= pc + ADDR_W'(1);
        req_addr <= pc;
      end
    end
  end

  // Buffer pointers and occupancy; a branch empties the buffer outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (is_branch_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage holds the returned word alongside the address it was read from.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rdata;
      buf_addr[wr_ptr] <= req_addr;
    end
  end

  // Decode-facing register: load head on pop, bubble when empty, hold on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (is_branch_taken) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instr       <= buf_data[rd_ptr];
        pc_out      <= buf_addr[rd_ptr];
        instr_valid <= 1'b1;
      end else begin
        instr       <= '0;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with output scoreboard
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        is_branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic [2:0]  fifo_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int sb_pops   = 0;

  logic [31:0] sb [$];
  logic [15:0] sb_next;
  logic [31:0] last_exp = '0;
  logic        stall_q  = 1'b0;
  logic        br_q     = 1'b0;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_branch_taken (is_branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, mem[a] = a ^ A000, junk when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ 16'hA000) : 16'hDEAD;
    stall_q    <= stall;
    br_q       <= is_branch_taken;
  end

  // Scoreboard: every freshly popped instruction must be the next expected one.
  always @(negedge clk) begin
    if (reset && instr_valid && !stall_q && !br_q) begin
      total_cnt++;
      sb_pops++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got pc=%h instr=%h with empty queue", pc_out, instr);
      end else begin
        last_exp = sb.pop_front();
        if ({pc_out, instr} !== last_exp)
          $display("FAIL sb_stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   pc_out, instr, last_exp[31:16], last_exp[15:0]);
        else
          pass_cnt++;
        sb.push_back({sb_next, sb_next ^ 16'hA000});
        sb_next = sb_next + 16'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic sb_reset(input logic [15:0] start);
    sb.delete();
    sb_next = start;
    for (int i = 0; i < 8; i++) begin
      sb.push_back({sb_next, sb_next ^ 16'hA000});
      sb_next = sb_next + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; is_branch_taken = 1'b0; branch_target = '0;
    repeat (3) tick();
    @(negedge clk);
    total_cnt += 5;
    if (instr !== 16'h0)      $display("FAIL reset_instr: got %h expected 0000", instr);       else pass_cnt++;
    if (pc_out !== 16'h0)     $display("FAIL reset_pc_out: got %h expected 0000", pc_out);     else pass_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid);    else pass_cnt++;
    if (fifo_count !== 3'd0)  $display("FAIL reset_count: got %0d expected 0", fifo_count);    else pass_cnt++;
    if (imem_req !== 1'b0)    $display("FAIL reset_req: got %b expected 0", imem_req);         else pass_cnt++;
    tick();
  endtask

  task automatic test_startup();
    int pops0;
    sb_reset(16'h0000);
    reset = 1'b1;
    pops0 = sb_pops;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total_cnt += 2;
        if (imem_req !== 1'b1)     $display("FAIL start_req: got %b expected 1", imem_req);     else pass_cnt++;
        if (imem_addr !== 16'h0)   $display("FAIL start_addr: got %h expected 0000", imem_addr); else pass_cnt++;
      end
      if (c == 2) begin
        total_cnt++;
        if (instr_valid !== 1'b0)  $display("FAIL start_early_valid: got %b expected 0", instr_valid); else pass_cnt++;
      end
      if (c >= 3) begin
        total_cnt++;
        if (instr_valid !== 1'b1)  $display("FAIL start_gap c=%0d: got %b expected 1", c, instr_valid); else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (sb_pops - pops0 !== 7) $display("FAIL start_pops: got %0d expected 7", sb_pops - pops0); else pass_cnt++;
  endtask

  task automatic test_stall();
    int pops0;
    stall = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 5) begin
        total_cnt += 2;
        if (instr !== last_exp[15:0])   $display("FAIL stall_hold_instr i=%0d: got %h expected %h", i, instr, last_exp[15:0]); else pass_cnt++;
        if (pc_out !== last_exp[31:16]) $display("FAIL stall_hold_pc i=%0d: got %h expected %h", i, pc_out, last_exp[31:16]); else pass_cnt++;
      end
      if (i == 5) begin
        total_cnt += 2;
        if (fifo_count !== 3'd4) $display("FAIL stall_full: got %0d expected 4", fifo_count); else pass_cnt++;
        if (imem_req !== 1'b0)   $display("FAIL stall_req_drop: got %b expected 0", imem_req); else pass_cnt++;
      end
      if (i == 6) begin
        total_cnt++;
        if (imem_req !== 1'b1)   $display("FAIL stall_req_resume: got %b expected 1", imem_req); else pass_cnt++;
      end
      tick();
      if (i == 5) stall = 1'b0;
    end
    pops0 = sb_pops;
    repeat (8) tick();
    total_cnt++;
    if (sb_pops - pops0 !== 8) $display("FAIL stall_resume_pops: got %0d expected 8", sb_pops - pops0); else pass_cnt++;
  endtask

  task automatic test_branch_stall();
    stall = 1'b1; is_branch_taken = 1'b1; branch_target = 16'h0010;
    @(negedge clk);
    total_cnt++;
    if (imem_req !== 1'b0) $display("FAIL bst_req_in_b: got %b expected 0", imem_req); else pass_cnt++;
    tick();
    is_branch_taken = 1'b0; stall = 1'b0;
    sb_reset(16'h0010);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total_cnt += 4;
        if (instr_valid !== 1'b0)  $display("FAIL bst_valid: got %b expected 0", instr_valid);  else pass_cnt++;
        if (instr !== 16'h0)       $display("FAIL bst_instr: got %h expected 0000", instr);     else pass_cnt++;
        if (fifo_count !== 3'd0)   $display("FAIL bst_count: got %0d expected 0", fifo_count);  else pass_cnt++;
        if (imem_addr !== 16'h0010) $display("FAIL bst_addr: got %h expected 0010", imem_addr); else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++;
        if (instr_valid !== 1'b0)  $display("FAIL bst_early_valid: got %b expected 0", instr_valid); else pass_cnt++;
      end
      if (k == 4) begin
        total_cnt += 2;
        if (instr_valid !== 1'b1)  $display("FAIL bst_target_valid: got %b expected 1", instr_valid); else pass_cnt++;
        if (pc_out !== 16'h0010)   $display("FAIL bst_target_pc: got %h expected 0010", pc_out);    else pass_cnt++;
      end
      tick();
    end
    repeat (6) tick();
  endtask

  task automatic test_branch();
    stall = 1'b1;
    repeat (2) tick();
    stall = 1'b0; is_branch_taken = 1'b1; branch_target = 16'h0040;
    @(negedge clk);
    total_cnt += 2;
    if (fifo_count !== 3'd3) $display("FAIL br_pre_count: got %0d expected 3", fifo_count); else pass_cnt++;
    if (imem_req !== 1'b0)   $display("FAIL br_req_in_b: got %b expected 0", imem_req);     else pass_cnt++;
    tick();
    is_branch_taken = 1'b0;
    sb_reset(16'h0040);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total_cnt += 4;
        if (fifo_count !== 3'd0)    $display("FAIL br_count: got %0d expected 0", fifo_count);   else pass_cnt++;
        if (instr_valid !== 1'b0)   $display("FAIL br_valid: got %b expected 0", instr_valid);   else pass_cnt++;
        if (imem_addr !== 16'h0040) $display("FAIL br_addr: got %h expected 0040", imem_addr);   else pass_cnt++;
        if (imem_req !== 1'b1)      $display("FAIL br_req: got %b expected 1", imem_req);        else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++;
        if (instr_valid !== 1'b0)   $display("FAIL br_early_valid: got %b expected 0", instr_valid); else pass_cnt++;
      end
      if (k == 4) begin
        total_cnt += 2;
        if (instr !== 16'hA040)     $display("FAIL br_target_instr: got %h expected A040", instr); else pass_cnt++;
        if (pc_out !== 16'h0040)    $display("FAIL br_target_pc: got %h expected 0040", pc_out);   else pass_cnt++;
      end
      tick();
    end
    repeat (6) tick();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0001;
    is_branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick();
    is_branch_taken = 1'b0;
    sb_reset(16'hFFFF);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        total_cnt += 3;
        if (instr_valid !== 1'b1) $display("FAIL wrap_valid k=%0d: got %b expected 1", k, instr_valid); else pass_cnt++;
        if (pc_out !== exp_pc[k-4]) $display("FAIL wrap_pc k=%0d: got %h expected %h", k, pc_out, exp_pc[k-4]); else pass_cnt++;
        if (instr !== (exp_pc[k-4] ^ 16'hA000))
          $display("FAIL wrap_instr k=%0d: got %h expected %h", k, instr, exp_pc[k-4] ^ 16'hA000);
        else pass_cnt++;
      end
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total_cnt += 5;
    if (instr !== 16'h0)      $display("FAIL areset_instr: got %h expected 0000", instr);    else pass_cnt++;
    if (pc_out !== 16'h0)     $display("FAIL areset_pc_out: got %h expected 0000", pc_out);  else pass_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", instr_valid); else pass_cnt++;
    if (fifo_count !== 3'd0)  $display("FAIL areset_count: got %0d expected 0", fifo_count); else pass_cnt++;
    if (imem_req !== 1'b0)    $display("FAIL areset_req: got %b expected 0", imem_req);      else pass_cnt++;
    repeat (2) tick();
    sb_reset(16'h0000);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total_cnt += 2;
        if (imem_req !== 1'b1)   $display("FAIL areset_restart_req: got %b expected 1", imem_req);   else pass_cnt++;
        if (imem_addr !== 16'h0) $display("FAIL areset_restart_addr: got %h expected 0000", imem_addr); else pass_cnt++;
      end
      if (c == 3) begin
        total_cnt += 3;
        if (instr_valid !== 1'b1) $display("FAIL areset_first_valid: got %b expected 1", instr_valid); else pass_cnt++;
        if (pc_out !== 16'h0)     $display("FAIL areset_first_pc: got %h expected 0000", pc_out);      else pass_cnt++;
        if (instr !== 16'hA000)   $display("FAIL areset_first_instr: got %h expected A000", instr);    else pass_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_branch_stall();
    test_branch();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
